// File: rtl/jhash_core_if.sv
`default_nettype none
// ============================================================================
// Module   : jhash_core_if
// Brief    : Beat stream and hash result bundle between jhash_in, jhash_core
//            and the hash consumer.
// Revision : 1.0
// ============================================================================
interface jhash_core_if;
    logic [31:0] stream_data0;
    logic [31:0] stream_data1;
    logic [31:0] stream_data2;
    logic        stream_valid;
    logic        stream_done;
    logic [1:0]  stream_left;
    logic        stream_ack;
    logic [31:0] hash_out;
    logic        hash_valid;
    logic        hash_ready;

    modport master (
        output stream_data0, stream_data1, stream_data2,
        output stream_valid, stream_done, stream_left, hash_ready,
        input  stream_ack, hash_out, hash_valid
    );

    modport slave (
        input  stream_data0, stream_data1, stream_data2,
        input  stream_valid, stream_done, stream_left, hash_ready,
        output stream_ack, hash_out, hash_valid
    );
endinterface
`default_nettype wire

// File: rtl/jhash_core.sv
`default_nettype none
// ============================================================================
// Module   : jhash_core
// Brief    : Jenkins lookup2 hash engine, one 32-bit hash per message.
//            Build option JHASH_MIX_UNROLL_EN: full mix in one cycle.
// Revision : 1.0
// ============================================================================
module jhash_core #(
    parameter logic [31:0] INITVAL   = 32'h0000_0000,
    parameter int unsigned LEN_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    jhash_core_if.slave jh_io
);
    localparam logic [31:0] C_GOLDEN = 32'h9e37_79b9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MIX  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          a_q, a_d, b_q, b_d, c_q, c_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic                 last_q, last_d;
    logic                 ack_q, ack_d;
    logic                 hvalid_q, hvalid_d;
    logic [31:0]          hout_q, hout_d;
`ifndef JHASH_MIX_UNROLL_EN
    logic [1:0]           rnd_q, rnd_d;
`endif

    // One third of the lookup2 mix; each line sees the lines above it.
    function automatic logic [95:0] mix_third(
        input logic [31:0] a_i, b_i, c_i,
        input logic [4:0]  s0, s1, s2
    );
        logic [31:0] na, nb, nc;
        na = (a_i - b_i - c_i) ^ (c_i >> s0);
        nb = (b_i - c_i - na) ^ (na << s1);
        nc = (c_i - na - nb) ^ (nb >> s2);
        return {na, nb, nc};
    endfunction

    logic [1:0]           w_words;
    logic                 w_xfer, w_final;
    logic [31:0]          w_k1, w_k2;
    logic [3:0]           w_len_add;
    logic [LEN_WIDTH-1:0] w_len_sum;
    logic [95:0]          w_mix;

    assign w_xfer  = jh_io.stream_valid && ack_q;
    assign w_final = jh_io.stream_done;

    // Encoding 0 and the illegal 3 both mean a full beat.
    always_comb begin
        case (jh_io.stream_left)
            2'd1:    w_words = 2'd1;
            2'd2:    w_words = 2'd2;
            default: w_words = 2'd3;
        endcase
    end

    assign w_k1      = (w_final && (w_words == 2'd1)) ? 32'd0 : jh_io.stream_data1;
    assign w_k2      = (w_final && (w_words != 2'd3)) ? 32'd0 : jh_io.stream_data2;
    assign w_len_add = w_final ? {w_words, 2'b00} : 4'd12;
    assign w_len_sum = len_q + LEN_WIDTH'(w_len_add);

`ifdef JHASH_MIX_UNROLL_EN
    logic [95:0] w_m1, w_m2;
    assign w_m1  = mix_third(a_q, b_q, c_q, 5'd13, 5'd8, 5'd13);
    assign w_m2  = mix_third(w_m1[95:64], w_m1[63:32], w_m1[31:0], 5'd12, 5'd16, 5'd5);
    assign w_mix = mix_third(w_m2[95:64], w_m2[63:32], w_m2[31:0], 5'd3, 5'd10, 5'd15);
`else
    logic [4:0] w_s0, w_s1, w_s2;
    always_comb begin
        case (rnd_q)
            2'd0: begin w_s0 = 5'd13; w_s1 = 5'd8;  w_s2 = 5'd13; end
            2'd1: begin w_s0 = 5'd12; w_s1 = 5'd16; w_s2 = 5'd5;  end
            default: begin w_s0 = 5'd3; w_s1 = 5'd10; w_s2 = 5'd15; end
        endcase
    end
    assign w_mix = mix_third(a_q, b_q, c_q, w_s0, w_s1, w_s2);
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        len_d    = len_q;
        last_d   = last_q;
        ack_d    = 1'b0;
        hvalid_d = hvalid_q;
        hout_d   = hout_q;
`ifndef JHASH_MIX_UNROLL_EN
        rnd_d    = rnd_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ack_d = 1'b1;
                if (w_xfer) begin
                    a_d     = a_q + jh_io.stream_data0;
                    b_d     = b_q + w_k1;
                    c_d     = c_q + w_k2 + (w_final ? 32'(w_len_sum) : 32'd0);
                    len_d   = w_len_sum;
                    last_d  = w_final;
                    ack_d   = 1'b0;
                    state_d = ST_MIX;
`ifndef JHASH_MIX_UNROLL_EN
                    rnd_d   = 2'd0;
`endif
                end
            end
            ST_MIX: begin
                a_d = w_mix[95:64];
                b_d = w_mix[63:32];
                c_d = w_mix[31:0];
`ifndef JHASH_MIX_UNROLL_EN
                rnd_d = rnd_q + 2'd1;
                if (rnd_q == 2'd2) begin
                    rnd_d = 2'd0;
`endif
                    if (last_q) begin
                        state_d = ST_OUT;
                    end else begin
                        state_d = ST_IDLE;
                        ack_d   = 1'b1;
                    end
`ifndef JHASH_MIX_UNROLL_EN
                end
`endif
            end
            ST_OUT: begin
                // First OUT cycle registers the result; later cycles wait for the taker.
                if (!hvalid_q) begin
                    hvalid_d = 1'b1;
                    hout_d   = c_q;
                end else if (jh_io.hash_ready) begin
                    hvalid_d = 1'b0;
                    state_d  = ST_IDLE;
                    ack_d    = 1'b1;
                    last_d   = 1'b0;
                    a_d      = C_GOLDEN;
                    b_d      = C_GOLDEN;
                    c_d      = INITVAL;
                    len_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            a_q      <= C_GOLDEN;
            b_q      <= C_GOLDEN;
            c_q      <= INITVAL;
            len_q    <= '0;
            last_q   <= 1'b0;
            ack_q    <= 1'b0;
            hvalid_q <= 1'b0;
            hout_q   <= 32'd0;
`ifndef JHASH_MIX_UNROLL_EN
            rnd_q    <= 2'd0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            len_q    <= len_d;
            last_q   <= last_d;
            ack_q    <= ack_d;
            hvalid_q <= hvalid_d;
            hout_q   <= hout_d;
`ifndef JHASH_MIX_UNROLL_EN
            rnd_q    <= rnd_d;
`endif
        end
    end

    assign jh_io.stream_ack = ack_q;
    assign jh_io.hash_valid = hvalid_q;
    assign jh_io.hash_out   = hout_q;

endmodule
`default_nettype wire

// File: tb/tb_jhash_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_jhash_core
// Brief    : Scoreboard bench for jhash_core; two instances (INITVAL 0 and 1).
// Revision : 1.0
// ============================================================================
module tb_jhash_core;
`ifdef JHASH_MIX_UNROLL_EN
    localparam int ACK_LOW = 1;
    localparam int LAT     = 2;
`else
    localparam int ACK_LOW = 3;
    localparam int LAT     = 4;
`endif
    localparam logic [31:0] GOLDEN = 32'h9e37_79b9;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    jhash_core_if jh0();
    jhash_core_if jh1();

    assign jh1.stream_data0 = jh0.stream_data0;
    assign jh1.stream_data1 = jh0.stream_data1;
    assign jh1.stream_data2 = jh0.stream_data2;
    assign jh1.stream_valid = jh0.stream_valid;
    assign jh1.stream_done  = jh0.stream_done;
    assign jh1.stream_left  = jh0.stream_left;
    assign jh1.hash_ready   = jh0.hash_ready;

    jhash_core #(.INITVAL(32'h0000_0000), .LEN_WIDTH(32)) u_dut0 (
        .clk(clk), .rst(rst), .jh_io(jh0)
    );
    jhash_core #(.INITVAL(32'h0000_0001), .LEN_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst), .jh_io(jh1)
    );

    int          chk_cnt  = 0;
    int          pass_cnt = 0;
    int          hs_cnt   = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last_h0, last_h1;
    logic [31:0] m_a[2], m_b[2], m_c[2];
    logic [31:0] m_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [95:0] ref_mix(input logic [31:0] a_i, b_i, c_i);
        logic [31:0] a, b, c;
        a = a_i; b = b_i; c = c_i;
        a = a - b; a = a - c; a = a ^ (c >> 13);
        b = b - c; b = b - a; b = b ^ (a << 8);
        c = c - a; c = c - b; c = c ^ (b >> 13);
        a = a - b; a = a - c; a = a ^ (c >> 12);
        b = b - c; b = b - a; b = b ^ (a << 16);
        c = c - a; c = c - b; c = c ^ (b >> 5);
        a = a - b; a = a - c; a = a ^ (c >> 3);
        b = b - c; b = b - a; b = b ^ (a << 10);
        c = c - a; c = c - b; c = c ^ (b >> 15);
        return {a, b, c};
    endfunction

    task automatic model_init();
        for (int i = 0; i < 2; i++) begin
            m_a[i] = GOLDEN;
            m_b[i] = GOLDEN;
        end
        m_c[0] = 32'h0;
        m_c[1] = 32'h1;
        m_len  = 32'h0;
    endtask

    task automatic model_add(input logic [31:0] k0, k1, k2, input logic done, input logic [1:0] left);
        int          words;
        logic [31:0] k1m, k2m;
        words = (left == 2'd1) ? 1 : (left == 2'd2) ? 2 : 3;
        k1m   = (done && words < 2) ? 32'h0 : k1;
        k2m   = (done && words < 3) ? 32'h0 : k2;
        m_len = m_len + (done ? 32'(4 * words) : 32'd12);
        for (int i = 0; i < 2; i++) begin
            m_a[i] = m_a[i] + k0;
            m_b[i] = m_b[i] + k1m;
            m_c[i] = m_c[i] + k2m + (done ? m_len : 32'h0);
        end
    endtask

    task automatic model_mix(input logic done);
        for (int i = 0; i < 2; i++) {m_a[i], m_b[i], m_c[i]} = ref_mix(m_a[i], m_b[i], m_c[i]);
        if (done) begin
            q0.push_back(m_c[0]);
            q1.push_back(m_c[1]);
            model_init();
        end
    endtask

    // Drives one beat, checks pre-mix state, then ack-low length or hash latency.
    task automatic send_beat(input logic [31:0] k0, k1, k2, input logic done,
                             input logic [1:0] left, input bit quick,
                             output logic [31:0] a_pre, c_pre, len_pre);
        int n;
        @(negedge clk);
        jh0.stream_data0 = k0;
        jh0.stream_data1 = k1;
        jh0.stream_data2 = k2;
        jh0.stream_done  = done;
        jh0.stream_left  = left;
        jh0.stream_valid = 1'b1;
        n = 0;
        while (!jh0.stream_ack && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("ack_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        jh0.stream_valid = 1'b0;
        jh0.stream_done  = 1'b0;
        a_pre   = u_dut0.a_q;
        c_pre   = u_dut0.c_q;
        len_pre = u_dut0.len_q;
        model_add(k0, k1, k2, done, left);
        check("pre_a", a_pre, m_a[0]);
        check("pre_c", c_pre, m_c[0]);
        model_mix(done);
        if (!quick) begin
            if (!done) begin
                n = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (jh0.stream_ack) break;
                    n++;
                end
                check("ack_low_cycles", 32'(n), 32'(ACK_LOW));
            end else begin
                n = 0;
                do begin
                    @(posedge clk);
                    #1;
                    n++;
                end while (!jh0.hash_valid && n < 50);
                check("hash_latency", 32'(n), 32'(LAT));
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst && jh0.hash_valid && jh0.hash_ready) begin
            hs_cnt++;
            if (q0.size() == 0) begin
                check("unexpected_hash", jh0.hash_out, 32'hxxxx_xxxx);
            end else begin
                logic [31:0] e0, e1;
                e0 = q0.pop_front();
                e1 = q1.pop_front();
                check("hash_init0", jh0.hash_out, e0);
                check("hash_init1_valid", 32'(jh1.hash_valid), 32'd1);
                check("hash_init1", jh1.hash_out, e1);
                last_h0 = jh0.hash_out;
                last_h1 = jh1.hash_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ap, cp, lp, h_first, h_hold;
        int          bad, hs0, n;
        jh0.stream_data0 = 32'h0;
        jh0.stream_data1 = 32'h0;
        jh0.stream_data2 = 32'h0;
        jh0.stream_valid = 1'b0;
        jh0.stream_done  = 1'b0;
        jh0.stream_left  = 2'd0;
        jh0.hash_ready   = 1'b1;
        last_h0 = 32'h0;
        last_h1 = 32'h0;
        model_init();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(jh0.stream_ack), 32'd0);
        check("rst_hvalid", 32'(jh0.hash_valid), 32'd0);
        check("rst_hout", jh0.hash_out, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_after_release", 32'(jh0.stream_ack), 32'd1);

        // Single one-word final beat: unused words are masked, c = len = 4.
        send_beat(32'h6161_6161, 32'hffff_ffff, 32'h1234_5678, 1'b1, 2'd1, 1'b0, ap, cp, lp);
        check("single_pre_a", ap, 32'hff98_db1a);
        check("single_pre_c", cp, 32'd4);
        check("single_len", lp, 32'd4);

        // Three full beats then a two-word final beat: len = 44.
        send_beat(32'h0102_0304, 32'h0506_0708, 32'h090a_0b0c, 1'b0, 2'd0, 1'b0, ap, cp, lp);
        send_beat(32'hcafe_f00d, 32'h1357_9bdf, 32'h2468_ace0, 1'b0, 2'd2, 1'b0, ap, cp, lp);
        send_beat(32'hffff_ffff, 32'h8000_0001, 32'h7fff_fffe, 1'b0, 2'd1, 1'b0, ap, cp, lp);
        send_beat(32'h1111_2222, 32'h3333_4444, 32'hdead_beef, 1'b1, 2'd2, 1'b0, ap, cp, lp);
        check("multi_len", lp, 32'd44);

        // Consumer stalls for 10 cycles.
        @(posedge clk);
        #1;
        jh0.hash_ready = 1'b0;
        send_beat(32'h0bad_cafe, 32'h0000_0001, 32'h8000_0000, 1'b1, 2'd0, 1'b0, ap, cp, lp);
        h_hold = jh0.hash_out;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!jh0.hash_valid || jh0.hash_out !== h_hold || jh0.stream_ack) bad++;
        end
        check("stall_stable", 32'(bad), 32'd0);
        hs0 = hs_cnt;
        @(posedge clk);
        #1;
        jh0.hash_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_hvalid", 32'(jh0.hash_valid), 32'd0);
        check("stall_release_ack", 32'(jh0.stream_ack), 32'd1);
        repeat (3) @(posedge clk);
        check("stall_one_handshake", 32'(hs_cnt), 32'(hs0 + 1));

        // Identical back-to-back messages must hash identically.
        send_beat(32'h7465_7374, 32'h6461_7461, 32'h2121_2121, 1'b1, 2'd0, 1'b0, ap, cp, lp);
        @(posedge clk);
        #1;
        h_first = last_h0;
        send_beat(32'h7465_7374, 32'h6461_7461, 32'h2121_2121, 1'b1, 2'd0, 1'b0, ap, cp, lp);
        @(posedge clk);
        #1;
        check("reinit_same_hash", last_h0, h_first);
        check("initval_differs", 32'(last_h0 != last_h1), 32'd1);

        // Illegal left = 3 behaves as a full final beat.
        send_beat(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 2'd3, 1'b0, ap, cp, lp);
        send_beat(32'ha5a5_a5a5, 32'h5a5a_5a5a, 32'h0f0f_0f0f, 1'b1, 2'd3, 1'b0, ap, cp, lp);
        check("left3_len", lp, 32'd24);

        // Reset while mixing discards the message.
        @(posedge clk);
        #1;
        send_beat(32'h1234_5678, 32'h9abc_def0, 32'h0fed_cba9, 1'b0, 2'd0, 1'b1, ap, cp, lp);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midmix_rst_ack", 32'(jh0.stream_ack), 32'd0);
        check("midmix_rst_hvalid", 32'(jh0.hash_valid), 32'd0);
        check("midmix_rst_hout", jh0.hash_out, 32'd0);
        model_init();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midmix_release_ack", 32'(jh0.stream_ack), 32'd1);
        send_beat(32'h1234_5678, 32'h9abc_def0, 32'h0fed_cba9, 1'b0, 2'd0, 1'b0, ap, cp, lp);
        send_beat(32'h0000_00ff, 32'hffff_0000, 32'h0000_0001, 1'b1, 2'd1, 1'b0, ap, cp, lp);
        check("post_rst_len", lp, 32'd16);

        n = 0;
        while (q0.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(q0.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
`default_nettype wire
